// File: rtl/traffic_phase_controller.sv
// Timed phase FSM for a two-road junction: the principal road rests in green, and the
// secondary road is served only after its vehicle sensor has raised a request.
module traffic_phase_controller #(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned T_PG_MIN = 10,
   parameter int unsigned T_PY     = 3,
   parameter int unsigned T_SG     = 8,
   parameter int unsigned T_SY     = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       SecSensor,
   output logic [1:0] StateFlag,
   output logic [7:0] SecondsLeft,
   output logic       Tick,
   output logic       ReqPending
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [7:0]    LOAD_PG    = 8'(T_PG_MIN);
   localparam logic [7:0]    LOAD_PY    = 8'(T_PY);
   localparam logic [7:0]    LOAD_SG    = 8'(T_SG);
   localparam logic [7:0]    LOAD_SY    = 8'(T_SY);

   // The encoding is the phase code seen by the header decoder, so the state is the output.
   typedef enum logic [1:0] {
      PG = 2'd0,
      PY = 2'd1,
      SG = 2'd2,
      SY = 2'd3
   } phase_t;

   phase_t        state;
   phase_t        state_nxt;
   logic [7:0]    secs;
   logic [7:0]    secs_nxt;
   logic [7:0]    secs_dec;
   logic [PW-1:0] presc;
   logic          tick_w;
   logic          sync1;
   logic          sync2;
   logic          req;
   logic          enter_sg;

   assign tick_w = (presc == PRESC_LAST);

   // NOTE: sequential state is written only with non-blocking assignments so every flop
   // samples the values from before the edge, regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
      end else if (tick_w) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Two-flop synchronizer; SecSensor is asynchronous to clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= SecSensor;
         sync2 <= sync1;
      end
   end

   assign enter_sg = (state_nxt == SG) && (state != SG);

   // Clearing on SG entry has priority so a request is consumed by the phase that serves it.
   always_ff @(posedge clk) begin
      if (rst) begin
         req <= 1'b0;
      end else if (enter_sg) begin
         req <= 1'b0;
      end else if (sync2) begin
         req <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= PG;
         secs  <= LOAD_PG;
      end else begin
         state <= state_nxt;
         secs  <= secs_nxt;
      end
   end

   assign secs_dec = (secs == 8'd0) ? 8'd0 : secs - 8'd1;

   // NOTE: both outputs of this block get a default before any branch, so no path can
   // leave them unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      secs_nxt  = secs;
      if (tick_w) begin
         secs_nxt = secs_dec;
         case (state)
            PG: begin
               // Green may be held past its minimum; it only yields to a pending request.
               if ((secs <= 8'd1) && req) begin
                  state_nxt = PY;
                  secs_nxt  = LOAD_PY;
               end
            end
            PY: begin
               if (secs == 8'd1) begin
                  state_nxt = SG;
                  secs_nxt  = LOAD_SG;
               end
            end
            SG: begin
               if (secs == 8'd1) begin
                  state_nxt = SY;
                  secs_nxt  = LOAD_SY;
               end
            end
            SY: begin
               if (secs == 8'd1) begin
                  state_nxt = PG;
                  secs_nxt  = LOAD_PG;
               end
            end
            default: begin
               state_nxt = PG;
               secs_nxt  = LOAD_PG;
            end
         endcase
      end
   end

   assign StateFlag   = state;
   assign SecondsLeft = secs;
   assign Tick        = tick_w;
   assign ReqPending  = req;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller with short timing (TICK_DIV=4, PG=3, PY=2, SG=4, SY=2).
// Cycle n is the clock period following the n-th rising edge after the reset edge (edge 0).
module tb_traffic_phase_controller;

   logic       clk;
   logic       rst;
   logic       SecSensor;
   logic [1:0] StateFlag;
   logic [7:0] SecondsLeft;
   logic       Tick;
   logic       ReqPending;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   traffic_phase_controller #(
      .TICK_DIV (4),
      .T_PG_MIN (3),
      .T_PY     (2),
      .T_SG     (4),
      .T_SY     (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .SecSensor   (SecSensor),
      .StateFlag   (StateFlag),
      .SecondsLeft (SecondsLeft),
      .Tick        (Tick),
      .ReqPending  (ReqPending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to cycle n; sampling point is 1 time unit after the rising edge.
   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      logic [7:0] exp_sl;
      logic       exp_tick;
      SecSensor = 1'b0;
      do_reset();
      for (int n = 0; n < 100; n++) begin
         goto(n);
         exp_sl   = (n < 4) ? 8'd3 : (n < 8) ? 8'd2 : (n < 12) ? 8'd1 : 8'd0;
         exp_tick = ((n % 4) == 3);
         n_checks++;
         if (StateFlag !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_state cyc=%0d got=%0d exp=0", n, StateFlag);
         end
         n_checks++;
         if (SecondsLeft !== exp_sl) begin
            n_fail++;
            $display("FAIL idle_secs cyc=%0d got=%0d exp=%0d", n, SecondsLeft, exp_sl);
         end
         n_checks++;
         if (Tick !== exp_tick) begin
            n_fail++;
            $display("FAIL idle_tick cyc=%0d got=%0b exp=%0b", n, Tick, exp_tick);
         end
         n_checks++;
         if (ReqPending !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_req cyc=%0d got=%0b exp=0", n, ReqPending);
         end
      end
   endtask

   task automatic test_single_request();
      // {cycle, phase, seconds, req}
      int exp_tab [10][4] = '{
         '{ 6, 0, 2, 0}, '{ 7, 0, 2, 1}, '{11, 0, 1, 1}, '{12, 1, 2, 1}, '{19, 1, 1, 1},
         '{20, 2, 4, 0}, '{35, 2, 1, 0}, '{36, 3, 2, 0}, '{43, 3, 1, 0}, '{44, 0, 3, 0}
      };
      SecSensor = 1'b0;
      do_reset();
      goto(4);
      SecSensor = 1'b1;
      goto(5);
      SecSensor = 1'b0;
      for (int i = 0; i < 10; i++) begin
         goto(exp_tab[i][0]);
         n_checks++;
         if (StateFlag !== 2'(exp_tab[i][1])) begin
            n_fail++;
            $display("FAIL single_state cyc=%0d got=%0d exp=%0d", cyc, StateFlag, exp_tab[i][1]);
         end
         n_checks++;
         if (SecondsLeft !== 8'(exp_tab[i][2])) begin
            n_fail++;
            $display("FAIL single_secs cyc=%0d got=%0d exp=%0d", cyc, SecondsLeft, exp_tab[i][2]);
         end
         n_checks++;
         if (ReqPending !== 1'(exp_tab[i][3])) begin
            n_fail++;
            $display("FAIL single_req cyc=%0d got=%0b exp=%0d", cyc, ReqPending, exp_tab[i][3]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int exp_tab [10][3] = '{
         '{11, 0, 1}, '{12, 1, 2}, '{20, 2, 4}, '{36, 3, 2}, '{44, 0, 3},
         '{55, 0, 1}, '{56, 1, 2}, '{88, 0, 3}, '{99, 0, 1}, '{100, 1, 2}
      };
      SecSensor = 1'b1;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         goto(exp_tab[i][0]);
         n_checks++;
         if (StateFlag !== 2'(exp_tab[i][1])) begin
            n_fail++;
            $display("FAIL b2b_state cyc=%0d got=%0d exp=%0d", cyc, StateFlag, exp_tab[i][1]);
         end
         n_checks++;
         if (SecondsLeft !== 8'(exp_tab[i][2])) begin
            n_fail++;
            $display("FAIL b2b_secs cyc=%0d got=%0d exp=%0d", cyc, SecondsLeft, exp_tab[i][2]);
         end
      end
      // Clear on SG entry, then the still-high sensor re-arms the request one cycle later.
      do_reset();
      goto(20);
      n_checks++;
      if (ReqPending !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_req_clear cyc=%0d got=%0b exp=0", cyc, ReqPending);
      end
      goto(21);
      n_checks++;
      if (ReqPending !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_req_reset cyc=%0d got=%0b exp=1", cyc, ReqPending);
      end
      SecSensor = 1'b0;
   endtask

   task automatic test_late_request();
      SecSensor = 1'b0;
      do_reset();
      goto(21);
      SecSensor = 1'b1;
      goto(22);
      SecSensor = 1'b0;
      goto(23);
      n_checks++;
      if ({StateFlag, SecondsLeft, ReqPending} !== {2'd0, 8'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL late_c23 got=%0d/%0d/%0b exp=0/0/0", StateFlag, SecondsLeft, ReqPending);
      end
      goto(24);
      n_checks++;
      if ({StateFlag, SecondsLeft, ReqPending} !== {2'd0, 8'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL late_c24 got=%0d/%0d/%0b exp=0/0/1", StateFlag, SecondsLeft, ReqPending);
      end
      goto(27);
      n_checks++;
      if ({StateFlag, SecondsLeft, Tick} !== {2'd0, 8'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL late_c27 got=%0d/%0d/%0b exp=0/0/1", StateFlag, SecondsLeft, Tick);
      end
      goto(28);
      n_checks++;
      if ({StateFlag, SecondsLeft} !== {2'd1, 8'd2}) begin
         n_fail++;
         $display("FAIL late_py_entry got=%0d/%0d exp=1/2", StateFlag, SecondsLeft);
      end
   endtask

   task automatic test_mid_reset();
      SecSensor = 1'b1;
      do_reset();
      goto(29);
      n_checks++;
      if ({StateFlag, SecondsLeft, ReqPending} !== {2'd2, 8'd2, 1'b1}) begin
         n_fail++;
         $display("FAIL midrst_pre got=%0d/%0d/%0b exp=2/2/1", StateFlag, SecondsLeft, ReqPending);
      end
      do_reset();
      SecSensor = 1'b0;
      n_checks++;
      if ({StateFlag, SecondsLeft, ReqPending, Tick} !== {2'd0, 8'd3, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL midrst_post got=%0d/%0d/%0b/%0b exp=0/3/0/0", StateFlag, SecondsLeft, ReqPending, Tick);
      end
      for (int n = 1; n < 4; n++) begin
         goto(n);
         n_checks++;
         if (Tick !== (n == 3)) begin
            n_fail++;
            $display("FAIL midrst_presc cyc=%0d got=%0b exp=%0b", n, Tick, (n == 3));
         end
         n_checks++;
         if (ReqPending !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_sync cyc=%0d got=%0b exp=0", n, ReqPending);
         end
      end
   endtask

   task automatic test_request_in_sy();
      SecSensor = 1'b0;
      do_reset();
      goto(4);
      SecSensor = 1'b1;
      goto(5);
      SecSensor = 1'b0;
      goto(36);
      n_checks++;
      if ({StateFlag, ReqPending} !== {2'd3, 1'b0}) begin
         n_fail++;
         $display("FAIL sy_entry got=%0d/%0b exp=3/0", StateFlag, ReqPending);
      end
      SecSensor = 1'b1;
      goto(40);
      SecSensor = 1'b0;
      goto(39);
      goto(44);
      n_checks++;
      if ({StateFlag, SecondsLeft, ReqPending} !== {2'd0, 8'd3, 1'b1}) begin
         n_fail++;
         $display("FAIL sy_pg_return got=%0d/%0d/%0b exp=0/3/1", StateFlag, SecondsLeft, ReqPending);
      end
      goto(55);
      n_checks++;
      if ({StateFlag, SecondsLeft} !== {2'd0, 8'd1}) begin
         n_fail++;
         $display("FAIL sy_pg_last got=%0d/%0d exp=0/1", StateFlag, SecondsLeft);
      end
      goto(56);
      n_checks++;
      if ({StateFlag, SecondsLeft} !== {2'd1, 8'd2}) begin
         n_fail++;
         $display("FAIL sy_py_entry got=%0d/%0d exp=1/2", StateFlag, SecondsLeft);
      end
   endtask

   initial begin
      rst       = 1'b1;
      SecSensor = 1'b0;
      test_reset();
      test_single_request();
      test_back_to_back();
      test_late_request();
      test_mid_reset();
      test_request_in_sy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
